// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT block sequencer: default sample width,
// controller state encoding and the four-lane coefficient beat.
package idct_pkg;

    localparam int IDCT_W = 25;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLR   = 2'd1,
        FEED  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [IDCT_W-1:0] lane1;
        logic signed [IDCT_W-1:0] lane2;
        logic signed [IDCT_W-1:0] lane3;
        logic signed [IDCT_W-1:0] lane4;
    } beat_t;

endpackage

// File: rtl/idct_beat_buffer.sv
// Block-sized register file holding one block of coefficient beats.
// Written one beat per accepted handshake, read through a registered port
// that returns zero whenever no read is requested so the core input is
// quiet outside the feed window.
module idct_beat_buffer
    import idct_pkg::*;
#(
    parameter int W     = IDCT_W,
    parameter int BEATS = 16,
    parameter int AW    = $clog2(BEATS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [4*W-1:0]  wr_data_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [4*W-1:0]  rd_data_o
);

    logic [4*W-1:0] mem_q [BEATS];
    logic [4*W-1:0] rd_q;

    // Storage needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; zero when idle so the core sees clean zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/idct_block_sequencer.sv
// Sequencer in front of the IDCT core. Collects a block of coefficient
// beats from a valid/ready source, pulses the core reset, streams the block
// into the core on contiguous cycles and frames the fixed-latency result
// stream with out_valid / out_last / blk_done.
module idct_block_sequencer
    import idct_pkg::*;
#(
    parameter int W          = IDCT_W,
    parameter int BEATS      = 16,
    parameter int LATENCY    = 8,
    parameter int RST_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_d_1,
    input  logic signed [W-1:0] in_d_2,
    input  logic signed [W-1:0] in_d_3,
    input  logic signed [W-1:0] in_d_4,
    output logic                core_reset,
    output logic signed [W-1:0] core_d_in_1,
    output logic signed [W-1:0] core_d_in_2,
    output logic signed [W-1:0] core_d_in_3,
    output logic signed [W-1:0] core_d_in_4,
    input  logic signed [W-1:0] core_d_out_5,
    input  logic signed [W-1:0] core_d_out_6,
    input  logic signed [W-1:0] core_d_out_7,
    input  logic signed [W-1:0] core_d_out_8,
    output logic                out_valid,
    output logic signed [W-1:0] out_d_5,
    output logic signed [W-1:0] out_d_6,
    output logic signed [W-1:0] out_d_7,
    output logic signed [W-1:0] out_d_8,
    output logic                out_last,
    output logic                blk_done,
    output logic                busy
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int T_W   = $clog2(LATENCY + BEATS + 1);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam int AW    = $clog2(BEATS);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BEATS - 1);
    localparam logic [T_W-1:0]   T_FEED_LAST = T_W'(BEATS - 1);
    localparam logic [T_W-1:0]   T_CAP_FIRST = T_W'(LATENCY);
    localparam logic [T_W-1:0]   T_CAP_LAST  = T_W'(LATENCY + BEATS - 1);
    localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(RST_CYCLES - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [T_W-1:0]     t_q;
    logic [RC_W-1:0]    rc_q;
    logic               in_ready_q;
    logic               core_reset_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               blk_done_q;
    logic [4*W-1:0]     out_d_q;

    logic               accept;
    logic               rd_en_d;
    logic [AW-1:0]      rd_addr_d;
    logic [4*W-1:0]     rd_data;

    assign accept = in_valid & in_ready_q;

    idct_beat_buffer #(
        .W     (W),
        .BEATS (BEATS),
        .AW    (AW)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept),
        .wr_addr_i (AW'(cnt_q)),
        .wr_data_i ({in_d_1, in_d_2, in_d_3, in_d_4}),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (rd_data)
    );

    // Read one beat ahead: beat 0 in the last reset cycle, beat t+1 while feeding beat t.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        case (state_q)
            CLR: begin
                if (rc_q == RC_LAST) begin
                    rd_en_d = 1'b1;
                end
            end
            FEED: begin
                if (t_q < T_FEED_LAST) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = AW'(t_q + T_W'(1));
                end
            end
            default: begin
            end
        endcase
    end

    // Controller: load, core reset pulse, gap-free feed and output framing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            t_q          <= '0;
            rc_q         <= '0;
            in_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            blk_done_q   <= 1'b0;
            out_d_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            blk_done_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    core_reset_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q      <= CLR;
                            in_ready_q   <= 1'b0;
                            core_reset_q <= 1'b1;
                            rc_q         <= '0;
                        end
                    end
                end
                CLR: begin
                    if (rc_q == RC_LAST) begin
                        state_q      <= FEED;
                        t_q          <= '0;
                        core_reset_q <= 1'b0;
                    end else begin
                        rc_q <= rc_q + RC_W'(1);
                    end
                end
                FEED, DRAIN: begin
                    t_q <= t_q + T_W'(1);
                    if (state_q == FEED && t_q == T_FEED_LAST) begin
                        state_q <= DRAIN;
                    end
                    if (t_q >= T_CAP_FIRST) begin
                        out_valid_q <= 1'b1;
                        out_d_q     <= {core_d_out_5, core_d_out_6, core_d_out_7, core_d_out_8};
                        if (t_q == T_CAP_LAST) begin
                            out_last_q <= 1'b1;
                            blk_done_q <= 1'b1;
                            state_q    <= LOAD;
                            cnt_q      <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign core_reset  = core_reset_q;
    assign core_d_in_1 = rd_data[4*W-1:3*W];
    assign core_d_in_2 = rd_data[3*W-1:2*W];
    assign core_d_in_3 = rd_data[2*W-1:W];
    assign core_d_in_4 = rd_data[W-1:0];
    assign out_valid   = out_valid_q;
    assign out_d_5     = out_d_q[4*W-1:3*W];
    assign out_d_6     = out_d_q[3*W-1:2*W];
    assign out_d_7     = out_d_q[2*W-1:W];
    assign out_d_8     = out_d_q[W-1:0];
    assign out_last    = out_last_q;
    assign blk_done    = blk_done_q;
    assign busy        = (state_q != LOAD);

endmodule
